reg_status_file: RTL and testbench
==================================

Name: reg_status_file

Overview:
- Architectural register file plus register-result-status (tag) table, directly upstream of the reservation-station units (ALU, mul, div, load/store).
- On issue it supplies each source operand as either a value (q=0) or a producer tag, and renames the destination register to the issuing station's tag.
- It snoops the common data bus and retires pending tags by writing the broadcast value.

Parameters:
NREG, 32, number of architectural registers; register 0 is hardwired to zero.
AW, 5, register address width.
TAG_W, 8, station tag width: {unit id [7:3], station index [2:0]}; tag 0 means "value ready".
DW, 32, data width.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
cdb  in  41  common data bus: [40] valid, [39:32] tag, [31:0] value.
issue  in  1  an instruction issues this cycle.
rs1_addr  in  AW  source 1 register.
rs2_addr  in  AW  source 2 register.
rd_we  in  1  issuing instruction writes a destination.
rd_addr  in  AW  destination register.
rd_tag  in  TAG_W  tag of the reservation station receiving the instruction.
pre_we  in  1  direct preload write (bench/boot); writes value and clears tag.
pre_addr  in  AW  preload register.
pre_data  in  DW  preload value.
q1_out  out  TAG_W  source 1 producer tag (0 = v1_out valid).
v1_out  out  DW  source 1 value.
q2_out  out  TAG_W  source 2 producer tag.
v2_out  out  DW  source 2 value.
pending  out  AW+1  registered count of registers with a nonzero tag.

Behaviour:
- Reset (async, rst=1): all values 0, all tags 0, pending=0. Read outputs follow combinationally: q=0, v=0.
- Reads are combinational for each source s:
  - tag[s]==0: q=0, v=value[s].
  - tag[s]!=0 and cdb[40] and cdb[39:32]==tag[s] (same-cycle bypass): q=0, v=cdb[31:0].
  - otherwise: q=tag[s], v=0.
  - Reads always see pre-edge state, so rs==rd in the same issue gets the old mapping.
- Register 0: reads always give q=0, v=0. Rename, preload and CDB writes to it are ignored.
- Clock edge, applied per register in priority order, lowest first:
  1. CDB: if cdb[40], cdb tag !=0 and tag[r]==cdb tag, then value[r]<=cdb data and tag[r]<=0. Multiple registers may match; all are updated.
  2. Preload: if pre_we and pre_addr==r, then value[r]<=pre_data and tag[r]<=0. Preload overrides the CDB value.
  3. Rename: if issue, rd_we, rd_addr==r, r!=0 and rd_tag!=0, then tag[r]<=rd_tag. The value field is left as stages 1-2 wrote it. Rename wins the tag over CDB clear and preload.
- rd_tag==0 with rd_we: the rename is ignored (no tag change).
- A CDB with valid=1 and tag=0 is ignored.
- issue=0: rd_* and rs*_addr are ignored for state; read outputs stay combinational.
- pending is registered: it equals the popcount of nonzero tags after the edge, updated each cycle, and ranges 0..NREG-1.
- No handshake/backpressure: the issue stall decision belongs to the stations' all_busy; this block accepts every cycle.
- Reset mid-operation: all in-flight tags are dropped. Later CDB broadcasts of old tags match nothing.

Decomposition:
- Shared package: CDB field positions (valid bit 40, tag [39:32], data [31:0]), CDB width 41, unit-output width 40, TAG_NONE=0, unit id codes (div = 5'b00100, etc.), TAG_W/DW constants.
- Sub-module reg_status_entry: one register's value+tag with the CDB/preload/rename priority logic, instantiated NREG-1 times via generate.
- Top level: read muxes with bypass, the register-0 constant and the popcount.

Test Plan:
- Reset, then read rs1=3, rs2=0 -> q1=0, v1=0, q2=0, v2=0, pending=0.
- Preload r3=7; next cycle issue rs1=3, rd=5, rd_tag=8'b00100_001 -> q1=0, v1=7. After the edge a read of r5 gives q=8'b00100_001, v=0; pending=1.
- With r5 pending 8'b00100_001, drive cdb={1,8'b00100_001,32'd9} and read rs2=5 in the same cycle -> q2=0, v2=9 (bypass). After the edge r5 reads q=0, v=9; pending=0.
- Rename r4 and r6 both to tag 8'h21, then broadcast {1,8'h21,32'd42} -> both read 42 with q=0 on the next cycle.
- Same cycle: CDB clears r5 tag T1 while issue renames r5 to T2=8'h22 -> r5 q=8'h22, internal value = CDB data; pending unchanged at 1. Also issue rs1=5, rd=5 -> q1=0, v1=CDB data (old mapping + bypass).
- Rename r0 with tag 8'h21 -> r0 reads q=0, v=0, pending=0. Assert rst mid-flight with r7 pending -> all q=0 immediately; a later CDB of that tag changes nothing.

Source files
------------

// File: rtl/reg_status_file_pkg.sv
// Shared constants and types for the register file / register-result-status table.
// CDB layout, tag encoding and unit identifiers used by the issue stage and the stations.
package reg_status_file_pkg;

    localparam int unsigned NREG  = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned TAG_W = 8;
    localparam int unsigned DW    = 32;

    localparam int unsigned CDB_W       = 41;
    localparam int unsigned UNIT_OUT_W  = 40;
    localparam int unsigned CDB_VALID   = 40;
    localparam int unsigned CDB_TAG_HI  = 39;
    localparam int unsigned CDB_TAG_LO  = 32;
    localparam int unsigned CDB_DATA_HI = 31;

    localparam logic [TAG_W-1:0] TAG_NONE = '0;

    // Tag = {unit id, station index}; unit id occupies tag[7:3].
    typedef enum logic [4:0] {
        UNIT_ALU = 5'b00001,
        UNIT_MUL = 5'b00010,
        UNIT_DIV = 5'b00100,
        UNIT_LS  = 5'b01000
    } unit_id_e;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [DW-1:0]    data;
    } cdb_t;

    function automatic logic [TAG_W-1:0] make_tag(input unit_id_e unit, input logic [2:0] idx);
        return {unit, idx};
    endfunction

endpackage

// File: rtl/reg_status_entry.sv
// One architectural register: value plus producer tag.
// Per-edge priority: CDB retire, then preload (value and tag), then rename (tag only).
module reg_status_entry
    import reg_status_file_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_cdb_valid,
    input  logic [TAG_W-1:0] i_cdb_tag,
    input  logic [DW-1:0]    i_cdb_data,
    input  logic             i_pre_hit,
    input  logic [DW-1:0]    i_pre_data,
    input  logic             i_ren_hit,
    input  logic [TAG_W-1:0] i_ren_tag,
    output logic [DW-1:0]    o_value,
    output logic [TAG_W-1:0] o_tag,
    output logic             o_busy_next
);

    logic [DW-1:0]    r_value;
    logic [TAG_W-1:0] r_tag;
    logic [DW-1:0]    w_value_nxt;
    logic [TAG_W-1:0] w_tag_nxt;
    logic             w_cdb_hit;

    always_comb begin
        w_cdb_hit   = i_cdb_valid && (i_cdb_tag != TAG_NONE) && (r_tag == i_cdb_tag);
        w_value_nxt = r_value;
        w_tag_nxt   = r_tag;
        if (w_cdb_hit) begin
            w_value_nxt = i_cdb_data;
            w_tag_nxt   = TAG_NONE;
        end
        if (i_pre_hit) begin
            w_value_nxt = i_pre_data;
            w_tag_nxt   = TAG_NONE;
        end
        // Rename only claims the tag; the value keeps whatever retire/preload left.
        if (i_ren_hit) begin
            w_tag_nxt = i_ren_tag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_value <= '0;
            r_tag   <= TAG_NONE;
        end else begin
            r_value <= w_value_nxt;
            r_tag   <= w_tag_nxt;
        end
    end

    assign o_value     = r_value;
    assign o_tag       = r_tag;
    assign o_busy_next = (w_tag_nxt != TAG_NONE);

endmodule

// File: rtl/reg_status_file.sv
// Register file with rename tags feeding the reservation stations.
// Source reads are combinational with same-cycle CDB bypass; register 0 reads as constant zero.
module reg_status_file
    import reg_status_file_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [CDB_W-1:0] cdb,
    input  logic             issue,
    input  logic [AW-1:0]    rs1_addr,
    input  logic [AW-1:0]    rs2_addr,
    input  logic             rd_we,
    input  logic [AW-1:0]    rd_addr,
    input  logic [TAG_W-1:0] rd_tag,
    input  logic             pre_we,
    input  logic [AW-1:0]    pre_addr,
    input  logic [DW-1:0]    pre_data,
    output logic [TAG_W-1:0] q1_out,
    output logic [DW-1:0]    v1_out,
    output logic [TAG_W-1:0] q2_out,
    output logic [DW-1:0]    v2_out,
    output logic [AW:0]      pending
);

    cdb_t             w_cdb;
    logic [DW-1:0]    w_val [NREG];
    logic [TAG_W-1:0] w_tag [NREG];
    logic [NREG-1:0]  w_busy_nxt;
    logic [AW:0]      w_count;
    logic [AW:0]      r_pending;
    logic [TAG_W-1:0] w_t1, w_t2;

    assign w_cdb = cdb;

    assign w_val[0]      = '0;
    assign w_tag[0]      = TAG_NONE;
    assign w_busy_nxt[0] = 1'b0;

    for (genvar g = 1; g < NREG; g++) begin : g_entry
        logic w_pre_hit;
        logic w_ren_hit;

        assign w_pre_hit = pre_we && (pre_addr == AW'(g));
        assign w_ren_hit = issue && rd_we && (rd_addr == AW'(g)) && (rd_tag != TAG_NONE);

        reg_status_entry u_entry (
            .clk         (clk),
            .rst         (rst),
            .i_cdb_valid (w_cdb.valid),
            .i_cdb_tag   (w_cdb.tag),
            .i_cdb_data  (w_cdb.data),
            .i_pre_hit   (w_pre_hit),
            .i_pre_data  (pre_data),
            .i_ren_hit   (w_ren_hit),
            .i_ren_tag   (rd_tag),
            .o_value     (w_val[g]),
            .o_tag       (w_tag[g]),
            .o_busy_next (w_busy_nxt[g])
        );
    end

    always_comb begin
        w_t1   = w_tag[rs1_addr];
        q1_out = w_t1;
        v1_out = '0;
        if (w_t1 == TAG_NONE) begin
            v1_out = w_val[rs1_addr];
        end else if (w_cdb.valid && (w_cdb.tag == w_t1)) begin
            q1_out = TAG_NONE;
            v1_out = w_cdb.data;
        end
    end

    always_comb begin
        w_t2   = w_tag[rs2_addr];
        q2_out = w_t2;
        v2_out = '0;
        if (w_t2 == TAG_NONE) begin
            v2_out = w_val[rs2_addr];
        end else if (w_cdb.valid && (w_cdb.tag == w_t2)) begin
            q2_out = TAG_NONE;
            v2_out = w_cdb.data;
        end
    end

    // Counting next-state tags makes the registered count match the post-edge table.
    always_comb begin
        w_count = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            w_count = w_count + {{AW{1'b0}}, w_busy_nxt[i]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_count;
        end
    end

    assign pending = r_pending;

endmodule

// File: tb/tb_reg_status_file.sv
// Directed bench for reg_status_file: inputs change on the falling edge, outputs checked
// just after, so combinational reads see pre-edge state and registered state after the edge.
module tb_reg_status_file;

    logic        clk = 1'b0;
    logic        rst;
    logic [40:0] cdb;
    logic        issue;
    logic [4:0]  rs1_addr, rs2_addr;
    logic        rd_we;
    logic [4:0]  rd_addr;
    logic [7:0]  rd_tag;
    logic        pre_we;
    logic [4:0]  pre_addr;
    logic [31:0] pre_data;
    logic [7:0]  q1_out, q2_out;
    logic [31:0] v1_out, v2_out;
    logic [5:0]  pending;

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;

    reg_status_file dut (
        .clk      (clk),
        .rst      (rst),
        .cdb      (cdb),
        .issue    (issue),
        .rs1_addr (rs1_addr),
        .rs2_addr (rs2_addr),
        .rd_we    (rd_we),
        .rd_addr  (rd_addr),
        .rd_tag   (rd_tag),
        .pre_we   (pre_we),
        .pre_addr (pre_addr),
        .pre_data (pre_data),
        .q1_out   (q1_out),
        .v1_out   (v1_out),
        .q2_out   (q2_out),
        .v2_out   (v2_out),
        .pending  (pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        issue    = 1'b0;
        rd_we    = 1'b0;
        rd_addr  = '0;
        rd_tag   = '0;
        pre_we   = 1'b0;
        pre_addr = '0;
        pre_data = '0;
        cdb      = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        idle();
    endtask

    task automatic do_issue(input logic [4:0] rd, input logic [7:0] t);
        issue   = 1'b1;
        rd_we   = 1'b1;
        rd_addr = rd;
        rd_tag  = t;
    endtask

    task automatic do_pre(input logic [4:0] a, input logic [31:0] d);
        pre_we   = 1'b1;
        pre_addr = a;
        pre_data = d;
    endtask

    task automatic do_cdb(input logic [7:0] t, input logic [31:0] d);
        cdb = {1'b1, t, d};
    endtask

    task automatic read(input logic [4:0] a1, input logic [4:0] a2);
        rs1_addr = a1;
        rs2_addr = a2;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        rs1_addr = 5'd3;
        rs2_addr = 5'd0;
        #2;
        check("rst_q1", 32'(q1_out), 32'h0);
        check("rst_v1", v1_out, 32'h0);
        check("rst_q2", 32'(q2_out), 32'h0);
        check("rst_v2", v2_out, 32'h0);
        check("rst_pending", 32'(pending), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // preload r3, then issue reading r3 and renaming r5
        do_pre(5'd3, 32'd7);
        tick();
        do_issue(5'd5, 8'h21);
        read(5'd3, 5'd0);
        check("iss_q1", 32'(q1_out), 32'h0);
        check("iss_v1", v1_out, 32'd7);
        check("iss_pend0", 32'(pending), 32'd0);
        tick();
        read(5'd5, 5'd0);
        check("ren_q1", 32'(q1_out), 32'h21);
        check("ren_v1", v1_out, 32'h0);
        check("ren_pend", 32'(pending), 32'd1);

        // same-cycle bypass on r5
        do_cdb(8'h21, 32'd9);
        read(5'd0, 5'd5);
        check("byp_q2", 32'(q2_out), 32'h0);
        check("byp_v2", v2_out, 32'd9);
        tick();
        read(5'd0, 5'd5);
        check("ret_q2", 32'(q2_out), 32'h0);
        check("ret_v2", v2_out, 32'd9);
        check("ret_pend", 32'(pending), 32'd0);

        // two registers share a tag; one broadcast retires both
        do_issue(5'd4, 8'h21);
        tick();
        do_issue(5'd6, 8'h21);
        tick();
        read(5'd4, 5'd6);
        check("multi_pend2", 32'(pending), 32'd2);
        check("multi_q1pre", 32'(q1_out), 32'h21);
        do_cdb(8'h21, 32'd42);
        tick();
        read(5'd4, 5'd6);
        check("multi_q1", 32'(q1_out), 32'h0);
        check("multi_v1", v1_out, 32'd42);
        check("multi_q2", 32'(q2_out), 32'h0);
        check("multi_v2", v2_out, 32'd42);
        check("multi_pend0", 32'(pending), 32'd0);

        // retire and re-rename of r5 in the same cycle
        do_issue(5'd5, 8'h21);
        tick();
        check("rr_pend1", 32'(pending), 32'd1);
        do_cdb(8'h21, 32'd55);
        do_issue(5'd5, 8'h22);
        read(5'd5, 5'd0);
        check("rr_q1_old", 32'(q1_out), 32'h0);
        check("rr_v1_old", v1_out, 32'd55);
        tick();
        read(5'd5, 5'd0);
        check("rr_q1_new", 32'(q1_out), 32'h22);
        check("rr_v1_new", v1_out, 32'h0);
        check("rr_pend", 32'(pending), 32'd1);
        do_cdb(8'h22, 32'd77);
        tick();
        read(5'd5, 5'd0);
        check("rr_ret_q1", 32'(q1_out), 32'h0);
        check("rr_ret_v1", v1_out, 32'd77);
        check("rr_ret_pend", 32'(pending), 32'd0);

        // register 0 ignores rename and preload
        do_issue(5'd0, 8'h21);
        do_pre(5'd0, 32'd99);
        tick();
        read(5'd0, 5'd0);
        check("r0_q1", 32'(q1_out), 32'h0);
        check("r0_v1", v1_out, 32'h0);
        check("r0_pend", 32'(pending), 32'd0);

        // valid CDB with tag 0 must neither bypass nor write ready registers
        do_pre(5'd9, 32'd5);
        tick();
        do_cdb(8'h00, 32'd99);
        read(5'd9, 5'd0);
        check("t0_byp_v1", v1_out, 32'd5);
        tick();
        read(5'd9, 5'd0);
        check("t0_q1", 32'(q1_out), 32'h0);
        check("t0_v1", v1_out, 32'd5);

        // preload beats CDB value
        do_issue(5'd11, 8'h32);
        tick();
        check("pc_pend1", 32'(pending), 32'd1);
        do_cdb(8'h32, 32'd11);
        do_pre(5'd11, 32'd12);
        tick();
        read(5'd11, 5'd0);
        check("pc_q1", 32'(q1_out), 32'h0);
        check("pc_v1", v1_out, 32'd12);
        check("pc_pend0", 32'(pending), 32'd0);

        // rename beats both CDB clear and preload for the tag
        do_issue(5'd10, 8'h30);
        tick();
        do_cdb(8'h30, 32'd11);
        do_pre(5'd10, 32'd12);
        do_issue(5'd10, 8'h31);
        tick();
        read(5'd10, 5'd0);
        check("rw_q1", 32'(q1_out), 32'h31);
        check("rw_v1", v1_out, 32'h0);
        check("rw_pend", 32'(pending), 32'd1);

        // rd_tag 0 and issue=0 leave the table alone
        do_issue(5'd3, 8'h00);
        tick();
        read(5'd3, 5'd0);
        check("tz_q1", 32'(q1_out), 32'h0);
        check("tz_v1", v1_out, 32'd7);
        rd_we   = 1'b1;
        rd_addr = 5'd3;
        rd_tag  = 8'h40;
        tick();
        read(5'd3, 5'd0);
        check("noiss_q1", 32'(q1_out), 32'h0);
        check("noiss_v1", v1_out, 32'd7);
        check("noiss_pend", 32'(pending), 32'd1);

        // reset mid-flight drops r7 and r10 tags
        do_issue(5'd7, 8'h41);
        tick();
        read(5'd7, 5'd10);
        check("mid_q1", 32'(q1_out), 32'h41);
        check("mid_pend", 32'(pending), 32'd2);
        rst = 1'b1;
        #1;
        check("arst_q1", 32'(q1_out), 32'h0);
        check("arst_q2", 32'(q2_out), 32'h0);
        check("arst_v2", v2_out, 32'h0);
        check("arst_pend", 32'(pending), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        do_cdb(8'h41, 32'd123);
        read(5'd7, 5'd3);
        check("stale_byp_v1", v1_out, 32'h0);
        check("stale_v2", v2_out, 32'h0);
        tick();
        read(5'd7, 5'd0);
        check("stale_q1", 32'(q1_out), 32'h0);
        check("stale_v1", v1_out, 32'h0);
        check("stale_pend", 32'(pending), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
